m_inst_loader: RTL

Upstream feeder of the microinstruction memory. Accepts a byte stream from the chip's 8-bit input pins, assembles 44-bit microinstructions little-endian, and writes them to consecutive memory addresses by driving the memory's `mode`, `m_pc` and `m_inst_load` inputs. When a load completes it hands the memory over to fetch: `mode` switches to FETCH and `m_pc` follows the sequencer's `fetch_pc`.

---
 rtl/ucpu_pkg.sv | 27 ++
 rtl/m_byte_assembler.sv | 63 ++++++
 rtl/m_inst_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ucpu_pkg.sv
// Shared definitions for the microinstruction loader, memory and sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Holds the memory mode encoding seen by the instruction memory, the loader
// state enum, and the default widths that the loader, memory and sequencer agree on.
package ucpu_pkg;

   localparam int MINST_WIDTH     = 44;
   localparam int DEPTH           = 1024;
   localparam int PC_WIDTH        = $clog2(DEPTH);
   localparam int BYTE_WIDTH      = 8;
   localparam int BYTES_PER_MINST = (MINST_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;

   // Memory mode encoding, shared with the memory and the sequencer.
   localparam logic [1:0] MODE_IDLE  = 2'd0;
   localparam logic [1:0] MODE_LOAD  = 2'd1;
   localparam logic [1:0] MODE_FETCH = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_FETCH   = 2'd3
   } ldr_state_e;

endpackage

// File: rtl/m_byte_assembler.sv
// Assembles a little-endian microinstruction from a stream of bytes.
// Latency: word/word_ready are combinational with the final byte's transfer strobe.
// Backpressure: none here; the parent only strobes xfer on an accepted byte.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   clear           drop any partial word (counter and holding register to 0)
//   xfer            a byte is accepted this cycle
//   byte_in         the byte being accepted
//   word_ready      this transfer completes a word
//   word            the completed word, valid while word_ready is high
module m_byte_assembler #(
   parameter int BYTE_WIDTH  = ucpu_pkg::BYTE_WIDTH,
   parameter int MINST_WIDTH = ucpu_pkg::MINST_WIDTH,
   parameter int NBYTES      = ucpu_pkg::BYTES_PER_MINST
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   xfer,
   input  logic [BYTE_WIDTH-1:0]  byte_in,
   output logic                   word_ready,
   output logic [MINST_WIDTH-1:0] word
);

   // Only the first NBYTES-1 bytes are held; the last byte is taken straight
   // from the input, so the word is complete in the same cycle it arrives.
   localparam int HOLD_W = (NBYTES - 1) * BYTE_WIDTH;
   localparam int TOP_W  = MINST_WIDTH - HOLD_W;
   localparam int CNT_W  = $clog2(NBYTES);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   assign word_ready = xfer && (cnt_q == CNT_W'(NBYTES - 1));
   // High bits of the final byte beyond MINST_WIDTH are dropped here.
   assign word       = {byte_in[TOP_W-1:0], hold_q};

   always_comb begin
      cnt_d  = cnt_q;
      hold_d = hold_q;
      if (clear) begin
         cnt_d  = '0;
         hold_d = '0;
      end else if (xfer) begin
         // Shift right so byte 0 lands in the lowest lane after NBYTES-1 shifts.
         // The shift on the final byte leaves junk that the next word overwrites.
         hold_d = {byte_in, hold_q[HOLD_W-1:BYTE_WIDTH]};
         cnt_d  = word_ready ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         hold_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/m_inst_loader.sv
// Loads microinstructions from the byte pins into instruction memory, then hands it to fetch.
// Latency: start->COLLECT 1 cycle; last byte->WRITE 1 cycle; gap-free stream = 1 word / 7 cycles.
// Backpressure: byte_ready is high only in COLLECT; the upstream holds bytes while it is low.
//
// Ports:
//   sys_clk, sys_rst_n        clock and synchronous active-low reset
//   load_start, load_words    begin a load of load_words words (clamped to DEPTH)
//   load_abort                cancel the load in progress, discarding the partial word
//   byte_valid/byte_ready     byte stream handshake, byte_data is the payload
//   fetch_pc                  sequencer PC, passed to m_pc while in FETCH
//   mode, m_pc, m_inst_load   memory control: mode, address and write data
//   busy, done                load in progress; one-cycle completion pulse
module m_inst_loader #(
   parameter int MINST_WIDTH = ucpu_pkg::MINST_WIDTH,
   parameter int DEPTH       = ucpu_pkg::DEPTH,
   parameter int PC_WIDTH    = ucpu_pkg::PC_WIDTH,
   parameter int BYTE_WIDTH  = ucpu_pkg::BYTE_WIDTH
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   load_start,
   input  logic [PC_WIDTH:0]      load_words,
   input  logic                   load_abort,
   input  logic                   byte_valid,
   input  logic [BYTE_WIDTH-1:0]  byte_data,
   output logic                   byte_ready,
   input  logic [PC_WIDTH-1:0]    fetch_pc,
   output logic [1:0]             mode,
   output logic [PC_WIDTH-1:0]    m_pc,
   output logic [MINST_WIDTH-1:0] m_inst_load,
   output logic                   busy,
   output logic                   done
);

   import ucpu_pkg::*;

   localparam int CW     = PC_WIDTH + 1;
   localparam int NBYTES = (MINST_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;

   ldr_state_e             state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic [PC_WIDTH-1:0]    addr_q, addr_d;
   logic [1:0]             mode_q, mode_d;
   logic [PC_WIDTH-1:0]    m_pc_q, m_pc_d;
   logic [MINST_WIDTH-1:0] m_inst_load_q, m_inst_load_d;
   logic                   byte_ready_q, byte_ready_d;
   logic                   done_q, done_d;

   logic                   asm_clear;
   logic                   asm_xfer;
   logic                   asm_word_ready;
   logic [MINST_WIDTH-1:0] asm_word;
   logic [CW-1:0]          words_clamped;
   logic                   last_word;

   assign words_clamped = (load_words > CW'(DEPTH)) ? CW'(DEPTH) : load_words;
   assign last_word     = ({1'b0, addr_q} == (count_q - 1'b1));

   // Abort wins over a byte offered in the same cycle.
   assign asm_xfer  = (state_q == ST_COLLECT) && byte_ready_q && byte_valid && !load_abort;
   // Outside COLLECT the assembler is held empty, so every load and every
   // restart after an abort begins on byte 0.
   assign asm_clear = (state_q != ST_COLLECT) || load_abort;

   m_byte_assembler #(
      .BYTE_WIDTH  (BYTE_WIDTH),
      .MINST_WIDTH (MINST_WIDTH),
      .NBYTES      (NBYTES)
   ) u_asm (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .clear      (asm_clear),
      .xfer       (asm_xfer),
      .byte_in    (byte_data),
      .word_ready (asm_word_ready),
      .word       (asm_word)
   );

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      addr_d        = addr_q;
      m_pc_d        = '0;
      m_inst_load_d = '0;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE, ST_FETCH: begin
            if (load_start) begin
               if (words_clamped != '0) begin
                  state_d = ST_COLLECT;
                  count_d = words_clamped;
                  addr_d  = '0;
               end else begin
                  state_d = ST_FETCH;
                  done_d  = 1'b1;
               end
            end
         end
         ST_COLLECT: begin
            if (load_abort) begin
               state_d = ST_IDLE;
            end else if (asm_word_ready) begin
               // Register address and data now so WRITE drives them from flops.
               state_d       = ST_WRITE;
               m_pc_d        = addr_q;
               m_inst_load_d = asm_word;
            end
         end
         ST_WRITE: begin
            // mode/m_pc/data for this cycle are already registered, so an abort
            // here only stops the load from advancing or completing.
            if (load_abort) begin
               state_d = ST_IDLE;
            end else if (last_word) begin
               state_d = ST_FETCH;
               done_d  = 1'b1;
            end else begin
               state_d = ST_COLLECT;
               addr_d  = addr_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered outputs follow the state being entered.
      case (state_d)
         ST_WRITE: mode_d = MODE_LOAD;
         ST_FETCH: mode_d = MODE_FETCH;
         default:  mode_d = MODE_IDLE;
      endcase
      byte_ready_d = (state_d == ST_COLLECT);
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q       <= ST_IDLE;
         count_q       <= '0;
         addr_q        <= '0;
         mode_q        <= MODE_IDLE;
         m_pc_q        <= '0;
         m_inst_load_q <= '0;
         byte_ready_q  <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         addr_q        <= addr_d;
         mode_q        <= mode_d;
         m_pc_q        <= m_pc_d;
         m_inst_load_q <= m_inst_load_d;
         byte_ready_q  <= byte_ready_d;
         done_q        <= done_d;
      end
   end

   assign mode        = mode_q;
   assign m_inst_load = m_inst_load_q;
   assign byte_ready  = byte_ready_q;
   assign done        = done_q;
   assign busy        = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
   // fetch_pc -> m_pc is the one combinational path through the loader.
   assign m_pc        = (state_q == ST_FETCH) ? fetch_pc : m_pc_q;

endmodule
